vx_csr_access_ctrl: RTL and testbench

Sequences and shares the single CSR read/write port of the per-core CSR data block between NUM_REQS requesters, such as the warp CSR unit and a debug/host port. Each request is a RISC-V CSR access (read, CSRRW, CSRRS or CSRRC). The controller turns it into a read phase, an optional write phase and a response carrying the old value, so read-modify-write is atomic with respect to the other requesters. It also drives the CSR block's busy input.

---
 rtl/vx_csr_access_ctrl_pkg.sv | 47 ++++
 rtl/vx_csr_access_ctrl_rr_arbiter.sv | 48 ++++
 rtl/vx_csr_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vx_csr_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_access_ctrl_pkg.sv
// Shared types for the CSR access controller: access opcodes, FSM states,
// CSR field widths and the read-modify-write operand helpers.
package vx_csr_access_ctrl_pkg;

  localparam int CSR_ADDR_BITS = 12;
  localparam int NW_BITS       = 4;
  localparam int UUID_BITS     = 44;

  typedef enum logic [1:0] {
    CSR_CTRL_OP_READ = 2'b00,
    CSR_CTRL_OP_RW   = 2'b01,
    CSR_CTRL_OP_RS   = 2'b10,
    CSR_CTRL_OP_RC   = 2'b11
  } csr_ctrl_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_ctrl_state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] csr_apply_op(input csr_ctrl_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_CTRL_OP_RW: res = operand;
      CSR_CTRL_OP_RS: res = old_val | operand;
      CSR_CTRL_OP_RC: res = old_val & ~operand;
      default:        res = old_val;
    endcase
    return res;
  endfunction

  // Set/clear with an all-zero mask must not touch the CSR (no side effects).
  function automatic logic csr_need_write(input csr_ctrl_op_e op,
                                          input logic [31:0] operand);
    return (op == CSR_CTRL_OP_RW) ||
           (((op == CSR_CTRL_OP_RS) || (op == CSR_CTRL_OP_RC)) && (operand != 32'd0));
  endfunction

endpackage

// File: rtl/vx_csr_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: scans from the priority pointer and moves the pointer
// one past the winner whenever a grant is taken.
module vx_csr_access_ctrl_rr_arbiter
  import vx_csr_access_ctrl_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int SEL_BITS = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [SEL_BITS-1:0] grant_index,
  output logic                grant_valid
);

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS:0]   cand;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    cand         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = {1'b0, ptr} + (SEL_BITS+1)'(i);
      if (cand >= (SEL_BITS+1)'(NUM_REQS))
        cand = cand - (SEL_BITS+1)'(NUM_REQS);
      for (int k = 0; k < NUM_REQS; k++) begin
        if (!grant_valid && (cand == (SEL_BITS+1)'(k)) && requests[k]) begin
          grant_valid     = 1'b1;
          grant_index     = SEL_BITS'(k);
          grant_onehot[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_index == SEL_BITS'(NUM_REQS-1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/vx_csr_access_ctrl.sv
// Shares the single CSR read/write port between requesters; each access runs
// read, optional write and response phases so read-modify-write stays atomic.
module vx_csr_access_ctrl
  import vx_csr_access_ctrl_pkg::*;
#(
  parameter int NUM_REQS     = 2,
  parameter int REQ_SEL_BITS = log2up(NUM_REQS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  output logic [NUM_REQS-1:0]             req_ready,
  input  logic [NUM_REQS*2-1:0]           req_op,
  input  logic [NUM_REQS*CSR_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
  input  logic [NUM_REQS*32-1:0]          req_data,
  input  logic [NUM_REQS*UUID_BITS-1:0]   req_uuid,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [REQ_SEL_BITS-1:0]         rsp_idx,
  output logic [31:0]                     rsp_data,
  output logic [UUID_BITS-1:0]            rsp_uuid,
  output logic                            read_enable,
  output logic [UUID_BITS-1:0]            read_uuid,
  output logic [CSR_ADDR_BITS-1:0]        read_addr,
  output logic [NW_BITS-1:0]              read_wid,
  input  logic [31:0]                     read_data,
  output logic                            write_enable,
  output logic [UUID_BITS-1:0]            write_uuid,
  output logic [CSR_ADDR_BITS-1:0]        write_addr,
  output logic [NW_BITS-1:0]              write_wid,
  output logic [31:0]                     write_data,
  output logic                            busy
);

  csr_ctrl_state_e state;

  logic [NUM_REQS-1:0]     grant_onehot;
  logic [REQ_SEL_BITS-1:0] grant_index;
  logic                    grant_valid;

  logic [1:0]               sel_op;
  logic [CSR_ADDR_BITS-1:0] sel_addr;
  logic [NW_BITS-1:0]       sel_wid;
  logic [31:0]              sel_data;
  logic [UUID_BITS-1:0]     sel_uuid;

  csr_ctrl_op_e             op_r;
  logic [CSR_ADDR_BITS-1:0] addr_r;
  logic [NW_BITS-1:0]       wid_r;
  logic [31:0]              data_r;
  logic [UUID_BITS-1:0]     uuid_r;
  logic [REQ_SEL_BITS-1:0]  idx_r;
  logic [31:0]              old_r;
  logic [31:0]              new_r;

  logic [31:0] new_val;
  logic        need_wr;

  vx_csr_access_ctrl_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .SEL_BITS (REQ_SEL_BITS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (req_valid),
    .advance      (state == ST_IDLE),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid)
  );

  assign req_ready = (state == ST_IDLE) ? grant_onehot : '0;

  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    sel_wid  = '0;
    sel_data = '0;
    sel_uuid = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_index == REQ_SEL_BITS'(i)) begin
        sel_op   = req_op[i*2 +: 2];
        sel_addr = req_addr[i*CSR_ADDR_BITS +: CSR_ADDR_BITS];
        sel_wid  = req_wid[i*NW_BITS +: NW_BITS];
        sel_data = req_data[i*32 +: 32];
        sel_uuid = req_uuid[i*UUID_BITS +: UUID_BITS];
      end
    end
  end

  assign new_val = csr_apply_op(op_r, read_data, data_r);
  assign need_wr = csr_need_write(op_r, data_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      op_r         <= CSR_CTRL_OP_READ;
      addr_r       <= '0;
      wid_r        <= '0;
      data_r       <= '0;
      uuid_r       <= '0;
      idx_r        <= '0;
      old_r        <= '0;
      new_r        <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            op_r        <= csr_ctrl_op_e'(sel_op);
            addr_r      <= sel_addr;
            wid_r       <= sel_wid;
            data_r      <= sel_data;
            uuid_r      <= sel_uuid;
            idx_r       <= grant_index;
            read_enable <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          // read_data is combinational from the CSR block, valid this cycle only.
          old_r       <= read_data;
          new_r       <= new_val;
          read_enable <= 1'b0;
          if (need_wr) begin
            write_enable <= 1'b1;
            state        <= ST_WRITE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          write_enable <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_idx    = idx_r;
  assign rsp_data   = old_r;
  assign rsp_uuid   = uuid_r;
  assign read_uuid  = uuid_r;
  assign read_addr  = addr_r;
  assign read_wid   = wid_r;
  assign write_uuid = uuid_r;
  assign write_addr = addr_r;
  assign write_wid  = wid_r;
  assign write_data = new_r;

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(req_ready));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable({rsp_idx, rsp_data, rsp_uuid})));
  a_ready_idle_only: assert property (@(posedge clk) disable iff (!reset)
    (state != ST_IDLE) |-> (req_ready == '0));
`endif

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
// Scoreboard bench for vx_csr_access_ctrl with two requesters and a small CSR
// memory model behind the read/write port.
module tb_vx_csr_access_ctrl;
  import vx_csr_access_ctrl_pkg::*;

  localparam int N  = 2;
  localparam int SB = 1;
  localparam int AB = CSR_ADDR_BITS;

  typedef struct packed {
    logic [1:0]           op;
    logic [AB-1:0]        addr;
    logic [NW_BITS-1:0]   wid;
    logic [31:0]          data;
    logic [UUID_BITS-1:0] uuid;
  } req_t;

  typedef struct packed {
    int                   idx;
    logic [AB-1:0]        addr;
    logic [31:0]          old;
    logic [UUID_BITS-1:0] uuid;
    int                   acc_cyc;
    int                   lat;
  } rsp_exp_t;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [31:0]   data;
  } wr_exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N*2-1:0]           req_op;
  logic [N*AB-1:0]          req_addr;
  logic [N*NW_BITS-1:0]     req_wid;
  logic [N*32-1:0]          req_data;
  logic [N*UUID_BITS-1:0]   req_uuid;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [SB-1:0]            rsp_idx;
  logic [31:0]              rsp_data;
  logic [UUID_BITS-1:0]     rsp_uuid;
  logic                     read_enable;
  logic [UUID_BITS-1:0]     read_uuid;
  logic [AB-1:0]            read_addr;
  logic [NW_BITS-1:0]       read_wid;
  logic [31:0]              read_data;
  logic                     write_enable;
  logic [UUID_BITS-1:0]     write_uuid;
  logic [AB-1:0]            write_addr;
  logic [NW_BITS-1:0]       write_wid;
  logic [31:0]              write_data;
  logic                     busy;

  vx_csr_access_ctrl #(.NUM_REQS(N), .REQ_SEL_BITS(SB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wid(req_wid), .req_data(req_data), .req_uuid(req_uuid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
    .rsp_data(rsp_data), .rsp_uuid(rsp_uuid),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_addr(read_addr),
    .read_wid(read_wid), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_addr(write_addr),
    .write_wid(write_wid), .write_data(write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // CSR block model; the bench preloads values through the poke port.
  logic [31:0]   csr_mem [0:4095];
  logic          poke_en;
  logic [AB-1:0] poke_addr;
  logic [31:0]   poke_val;
  assign read_data = csr_mem[read_addr];
  always @(posedge clk) begin
    if (write_enable) csr_mem[write_addr] <= write_data;
    if (poke_en) csr_mem[poke_addr] <= poke_val;
  end

  logic [31:0] ref_mem [0:4095];
  req_t        sq0[$];
  req_t        sq1[$];
  rsp_exp_t    rq[$];
  wr_exp_t     wq[$];
  int          gq[$];
  logic [N-1:0] acc;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_seen = 0;
  bit          rsp_seen = 0;
  logic [UUID_BITS-1:0] next_uuid = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_new(input logic [1:0] op, input logic [31:0] o,
                                            input logic [31:0] d);
    case (op)
      2'b01:   return d;
      2'b10:   return o | d;
      2'b11:   return o & ~d;
      default: return o;
    endcase
  endfunction

  task automatic monitor();
    req_t     r;
    rsp_exp_t e;
    wr_exp_t  w;
    logic     need;
    logic [31:0] nv;
    if (read_enable && write_enable) check_eq("rd_wr_exclusive", 1, 0);
    for (int p = 0; p < N; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        r = (p == 0) ? sq0[0] : sq1[0];
        need = (r.op == 2'b01) || (r.op[1] && (r.data != 32'd0));
        nv = model_new(r.op, ref_mem[r.addr], r.data);
        e.idx = p; e.addr = r.addr; e.old = ref_mem[r.addr]; e.uuid = r.uuid;
        e.acc_cyc = cyc; e.lat = need ? 3 : 2;
        rq.push_back(e);
        if (need) begin
          w.addr = r.addr; w.data = nv;
          wq.push_back(w);
          ref_mem[r.addr] = nv;
        end
        gq.push_back(p);
        acc[p] = 1'b1;
      end
    end
    if (read_enable) begin
      if (rq.size() == 0) check_eq("unexpected_read", 1, 0);
      else check_eq("read_addr", read_addr, rq[0].addr);
    end
    if (write_enable) begin
      wr_seen++;
      if (wq.size() == 0) check_eq("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        check_eq("write_addr", write_addr, w.addr);
        check_eq("write_data", write_data, w.data);
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) check_eq("unexpected_rsp", 1, 0);
      else begin
        if (!rsp_seen) check_eq("rsp_latency", cyc - rq[0].acc_cyc, rq[0].lat);
        check_eq("rsp_idx", rsp_idx, rq[0].idx);
        check_eq("rsp_data", rsp_data, rq[0].old);
        check_eq("rsp_uuid", rsp_uuid, rq[0].uuid);
        if (rsp_ready) void'(rq.pop_front());
      end
      rsp_seen = !rsp_ready;
    end
  endtask

  task automatic put(input int p, input req_t r);
    req_op[p*2 +: 2]                   = r.op;
    req_addr[p*AB +: AB]               = r.addr;
    req_wid[p*NW_BITS +: NW_BITS]      = r.wid;
    req_data[p*32 +: 32]               = r.data;
    req_uuid[p*UUID_BITS +: UUID_BITS] = r.uuid;
  endtask

  task automatic drive();
    if (acc[0] && sq0.size() > 0) sq0.delete(0);
    if (acc[1] && sq1.size() > 0) sq1.delete(0);
    acc = '0;
    req_valid[0] = (sq0.size() > 0);
    req_valid[1] = (sq1.size() > 0);
    if (sq0.size() > 0) put(0, sq0[0]);
    if (sq1.size() > 0) put(1, sq1[0]);
  endtask

  task automatic step();
    @(negedge clk);
    if (reset) monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic poke(input logic [AB-1:0] a, input logic [31:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    ref_mem[a] = v;
    step();
    poke_en = 1'b0;
  endtask

  task automatic push(input int p, input logic [1:0] op, input logic [AB-1:0] a,
                      input logic [31:0] d);
    req_t r;
    r.op = op; r.addr = a; r.wid = NW_BITS'(p + 2); r.data = d; r.uuid = next_uuid;
    next_uuid++;
    if (p == 0) sq0.push_back(r); else sq1.push_back(r);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((rq.size() != 0 || sq0.size() != 0 || sq1.size() != 0 || busy) && k < 300) begin
      step();
      k++;
    end
    check_eq(tag, (k < 300), 1);
  endtask

  initial begin
    int w0;
    int k;
    reset = 1'b0; rsp_ready = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    req_valid = '0; req_op = '0; req_addr = '0; req_wid = '0; req_data = '0; req_uuid = '0;
    acc = '0;
    step(); step();
    check_eq("reset_req_ready", req_ready, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rd_wr_en", {read_enable, write_enable}, 0);
    check_eq("reset_busy", busy, 0);
    reset = 1'b1;
    step();
    check_eq("idle_busy", busy, 0);

    // Single RW
    poke(12'h341, 32'h100);
    w0 = wr_seen;
    push(0, 2'b01, 12'h341, 32'h8000_0000);
    drain("rw_done");
    check_eq("rw_write_count", wr_seen - w0, 1);
    check_eq("rw_csr_value", csr_mem[12'h341], 32'h8000_0000);

    // RS with zero mask: no write
    poke(12'h300, 32'h8);
    w0 = wr_seen;
    push(1, 2'b10, 12'h300, 32'h0);
    drain("rs0_done");
    check_eq("rs0_write_count", wr_seen - w0, 0);

    // RC clears low nibble
    poke(12'h344, 32'hFF);
    push(0, 2'b11, 12'h344, 32'h0000_000F);
    drain("rc_done");
    check_eq("rc_csr_value", csr_mem[12'h344], 32'hF0);

    // Mixed random traffic on both ports
    for (int a = 0; a < 4; a++) poke(AB'(12'h3A0 + a), $urandom);
    for (int i = 0; i < 8; i++)
      push(i % 2, 2'($urandom_range(0, 3)), AB'(12'h3A0 + $urandom_range(0, 3)),
           (i == 5) ? 32'h0 : $urandom);
    drain("mixed_done");
    for (int a = 0; a < 4; a++)
      check_eq("mixed_csr_value", csr_mem[12'h3A0 + a], ref_mem[12'h3A0 + a]);

    // Backpressure
    rsp_ready = 1'b0;
    push(1, 2'b00, 12'h300, 32'h0);
    k = 0;
    while (!rsp_valid && k < 10) begin step(); k++; end
    check_eq("bp_rsp_arrived", rsp_valid, 1);
    push(0, 2'b01, 12'h341, 32'h5);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_req_ready", req_ready, 0);
      check_eq("bp_busy", busy, 1);
      check_eq("bp_rsp_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_release_grant", req_ready, 2'b01);
    drain("bp_done");

    // Reset in the READ cycle of an RW
    push(0, 2'b01, 12'h341, 32'h1234);
    k = 0;
    while (!read_enable && k < 10) begin step(); k++; end
    check_eq("abort_read_seen", read_enable, 1);
    reset = 1'b0;
    #1;
    check_eq("abort_read_en", read_enable, 0);
    check_eq("abort_busy", busy, 0);
    if (rq.size() > 0) begin
      ref_mem[rq[0].addr] = rq[0].old;
      rq.delete(0);
    end
    wq.delete();
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("abort_no_write", write_enable, 0);
      check_eq("abort_no_rsp", rsp_valid, 0);
    end
    reset = 1'b1;
    check_eq("abort_csr_kept", csr_mem[12'h341], 32'h5);

    // Fairness from a freshly reset pointer
    gq.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 2'b00, 12'h300, 32'h0);
      push(1, 2'b10, 12'h344, 32'h100 << i);
    end
    drain("fair_done");
    check_eq("fair_grants", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check_eq("fair_order", gq[i], i % 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
